// File: rtl/code_lock_if.sv
// Keypad-side and indicator-side signal bundle for code_lock_fsm.
// master drives keys/requests; slave (the lock) drives LEDs, buzzer and status.
interface code_lock_if #(
  parameter int KEY_W    = 3,
  parameter int MAX_FAIL = 3
);
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);

  logic              key_vld;
  logic [KEY_W-1:0]  key_code;
  logic              prog_req;
  logic              LED_right;
  logic              LED_wrong;
  logic              Buzzer;
  logic [FAIL_W-1:0] fail_cnt;
  logic              busy;

  modport master (
    output key_vld, key_code, prog_req,
    input  LED_right, LED_wrong, Buzzer, fail_cnt, busy
  );

  modport slave (
    input  key_vld, key_code, prog_req,
    output LED_right, LED_wrong, Buzzer, fail_cnt, busy
  );
endinterface

// File: rtl/code_lock_fsm.sv
// Keypad lock controller: compares CODE_LEN-digit entries, counts failures, locks out.
// Code reprogramming from the OPEN state is present only when CODE_LOCK_PROG_EN is defined.
module code_lock_fsm #(
  parameter int                          KEY_W        = 3,
  parameter int                          CODE_LEN     = 4,
  parameter logic [CODE_LEN*KEY_W-1:0]   DEFAULT_CODE = 12'b001_010_011_100,
  parameter int                          MAX_FAIL     = 3,
  parameter int                          HOLD_CYC     = 8,
  parameter int                          LOCKOUT_CYC  = 32,
  parameter int                          TIMEOUT_CYC  = 16
) (
  input  logic        clk,
  input  logic        clear,
  code_lock_if.slave  lock
);

  localparam int CODE_W = CODE_LEN * KEY_W;
  localparam int FW     = $clog2(MAX_FAIL + 1);
  localparam int IDX_W  = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int T_MAX1 = (HOLD_CYC > LOCKOUT_CYC) ? HOLD_CYC : LOCKOUT_CYC;
  localparam int T_MAX  = (T_MAX1 > TIMEOUT_CYC) ? T_MAX1 : TIMEOUT_CYC;
  localparam int TW     = $clog2(T_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_OPEN,
    S_FAIL,
    S_LOCKOUT
`ifdef CODE_LOCK_PROG_EN
    , S_PROG
`endif
  } state_t;

  state_t            state, state_nx;
  logic [IDX_W-1:0]  idx, idx_nx;
  logic [TW-1:0]     timer, timer_nx;
  logic              mismatch, mismatch_nx;
  logic [FW-1:0]     fail_cnt_r, fail_nx;
  logic [CODE_W-1:0] code_r;
  logic [KEY_W-1:0]  exp_digit;
  logic              digit_bad;
  logic              last_digit;
  logic              accepted;

`ifdef CODE_LOCK_PROG_EN
  logic [CODE_W-1:0] code_nx;
  logic [CODE_W-1:0] shadow, shadow_nx;
  logic [CODE_W-1:0] shadow_shift;
`else
  logic              unused_prog_req;

  assign code_r          = DEFAULT_CODE;
  assign unused_prog_req = lock.prog_req;
`endif

  // idx is held at 0 outside ENTRY/PROG, so IDLE naturally compares digit 0.
  assign exp_digit  = code_r[(CODE_LEN - 1 - int'(idx)) * KEY_W +: KEY_W];
  assign digit_bad  = (lock.key_code == '0) || (lock.key_code != exp_digit);
  assign last_digit = (int'(idx) == CODE_LEN - 1);

`ifdef CODE_LOCK_PROG_EN
  assign shadow_shift = (shadow << KEY_W) | CODE_W'(lock.key_code);
`endif

  always_comb begin
    state_nx    = state;
    idx_nx      = idx;
    mismatch_nx = mismatch;
    fail_nx     = fail_cnt_r;
    timer_nx    = timer + 1'b1;
    accepted    = 1'b0;
`ifdef CODE_LOCK_PROG_EN
    code_nx     = code_r;
    shadow_nx   = shadow;
`endif

    case (state)
      S_IDLE, S_ENTRY: begin
        if (lock.key_vld) begin
          accepted = 1'b1;
          if (last_digit) begin
            idx_nx      = '0;
            mismatch_nx = 1'b0;
            if (!(mismatch || digit_bad)) begin
              state_nx = S_OPEN;
              fail_nx  = '0;
            end else begin
              fail_nx  = fail_cnt_r + 1'b1;
              state_nx = (fail_cnt_r == FW'(MAX_FAIL - 1)) ? S_LOCKOUT : S_FAIL;
            end
          end else begin
            state_nx    = S_ENTRY;
            idx_nx      = idx + 1'b1;
            mismatch_nx = mismatch || digit_bad;
          end
        end else if (state == S_ENTRY && timer == TW'(TIMEOUT_CYC - 1)) begin
          state_nx    = S_IDLE;
          idx_nx      = '0;
          mismatch_nx = 1'b0;
        end
      end

      S_OPEN: begin
`ifdef CODE_LOCK_PROG_EN
        if (lock.prog_req) begin
          state_nx  = S_PROG;
          idx_nx    = '0;
          shadow_nx = '0;
        end else
`endif
        if (timer == TW'(HOLD_CYC - 1)) state_nx = S_IDLE;
      end

      S_FAIL: begin
        if (timer == TW'(HOLD_CYC - 1)) state_nx = S_IDLE;
      end

      S_LOCKOUT: begin
        if (timer == TW'(LOCKOUT_CYC - 1)) begin
          state_nx = S_IDLE;
          fail_nx  = '0;
        end
      end

`ifdef CODE_LOCK_PROG_EN
      S_PROG: begin
        if (lock.key_vld) begin
          accepted = 1'b1;
          if (lock.key_code == '0) begin
            state_nx = S_IDLE;
            idx_nx   = '0;
          end else if (last_digit) begin
            code_nx  = shadow_shift;
            state_nx = S_IDLE;
            idx_nx   = '0;
          end else begin
            shadow_nx = shadow_shift;
            idx_nx    = idx + 1'b1;
          end
        end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
          state_nx = S_IDLE;
          idx_nx   = '0;
        end
      end
`endif

      default: begin
        state_nx    = S_IDLE;
        idx_nx      = '0;
        mismatch_nx = 1'b0;
      end
    endcase

    if (accepted || state_nx != state || state == S_IDLE) timer_nx = '0;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state          <= S_IDLE;
      idx            <= '0;
      timer          <= '0;
      mismatch       <= 1'b0;
      fail_cnt_r     <= '0;
      lock.LED_right <= 1'b0;
      lock.LED_wrong <= 1'b0;
      lock.Buzzer    <= 1'b0;
      lock.busy      <= 1'b0;
    end else begin
      state          <= state_nx;
      idx            <= idx_nx;
      timer          <= timer_nx;
      mismatch       <= mismatch_nx;
      fail_cnt_r     <= fail_nx;
`ifdef CODE_LOCK_PROG_EN
      lock.LED_right <= (state == S_OPEN) || (state == S_PROG);
`else
      lock.LED_right <= (state == S_OPEN);
`endif
      lock.LED_wrong <= (state == S_FAIL);
      lock.Buzzer    <= (state == S_LOCKOUT);
      lock.busy      <= (state != S_IDLE);
    end
  end

`ifdef CODE_LOCK_PROG_EN
  always_ff @(posedge clk) begin
    if (clear) begin
      code_r <= DEFAULT_CODE;
      shadow <= '0;
    end else begin
      code_r <= code_nx;
      shadow <= shadow_nx;
    end
  end
`endif

  assign lock.fail_cnt = fail_cnt_r;

endmodule

// File: tb/tb_code_lock_fsm.sv
// Checks code_lock_fsm cycle by cycle against a digit-queue model of the lock's rules.
module tb_code_lock_fsm;
  localparam int KEY_W    = 3;
  localparam int CODE_LEN = 4;
  localparam int MAX_FAIL = 3;
  localparam int HOLD     = 8;
  localparam int LOCK     = 32;
  localparam int TMO      = 16;
  localparam logic [11:0] DEF = 12'b001_010_011_100;
`ifdef CODE_LOCK_PROG_EN
  localparam bit PROG_EN = 1'b1;
`else
  localparam bit PROG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic clear;

  code_lock_if #(.KEY_W(KEY_W), .MAX_FAIL(MAX_FAIL)) bus ();

  code_lock_fsm #(
    .KEY_W(KEY_W), .CODE_LEN(CODE_LEN), .DEFAULT_CODE(DEF), .MAX_FAIL(MAX_FAIL),
    .HOLD_CYC(HOLD), .LOCKOUT_CYC(LOCK), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .clear(clear), .lock(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: 0 idle, 1 entering, 2 open, 3 wrong, 4 lockout, 5 programming
  int m_mode = 0;
  int m_left = 0;
  int m_quiet = 0;
  int m_fails = 0;
  int m_keys[$];
  int m_code[CODE_LEN] = '{1, 2, 3, 4};
  logic [5:0] expv = '0;
  logic [5:0] obs;

  task automatic judge();
    bit ok = 1'b1;
    for (int i = 0; i < CODE_LEN; i++) if (m_keys[i] != m_code[i]) ok = 1'b0;
    m_keys.delete();
    if (ok) begin
      m_mode = 2; m_left = HOLD; m_fails = 0;
    end else begin
      m_fails++;
      if (m_fails == MAX_FAIL) begin m_mode = 4; m_left = LOCK; end
      else begin m_mode = 3; m_left = HOLD; end
    end
  endtask

  task automatic model(input bit v, input int k, input bit p, input bit c);
    bit r, w, b, bz;
    if (c) begin
      m_mode = 0; m_fails = 0; m_keys.delete(); m_code = '{1, 2, 3, 4};
      expv = '0;
      return;
    end
    r  = (m_mode == 2) || (m_mode == 5);
    w  = (m_mode == 3);
    b  = (m_mode == 4);
    bz = (m_mode != 0);
    case (m_mode)
      0, 1: begin
        if (v) begin
          m_keys.push_back(k); m_quiet = 0;
          if (m_keys.size() == CODE_LEN) judge(); else m_mode = 1;
        end else if (m_mode == 1) begin
          m_quiet++;
          if (m_quiet == TMO) begin m_mode = 0; m_keys.delete(); end
        end
      end
      2: begin
        if (PROG_EN && p) begin m_mode = 5; m_keys.delete(); m_quiet = 0; end
        else begin m_left--; if (m_left == 0) m_mode = 0; end
      end
      3: begin m_left--; if (m_left == 0) m_mode = 0; end
      4: begin m_left--; if (m_left == 0) begin m_mode = 0; m_fails = 0; end end
      5: begin
        if (v) begin
          m_quiet = 0;
          if (k == 0) begin m_mode = 0; m_keys.delete(); end
          else begin
            m_keys.push_back(k);
            if (m_keys.size() == CODE_LEN) begin
              for (int i = 0; i < CODE_LEN; i++) m_code[i] = m_keys[i];
              m_keys.delete(); m_mode = 0;
            end
          end
        end else begin
          m_quiet++;
          if (m_quiet == TMO) begin m_mode = 0; m_keys.delete(); end
        end
      end
      default: m_mode = 0;
    endcase
    expv = {r, w, b, bz, 2'(m_fails)};
  endtask

  task automatic step(input bit v, input int k, input bit p, input bit c, input string tag);
    bus.key_vld  = v;
    bus.key_code = KEY_W'(k);
    bus.prog_req = p;
    clear        = c;
    @(posedge clk);
    model(v, k, p, c);
    #1;
    obs = {bus.LED_right, bus.LED_wrong, bus.Buzzer, bus.busy, bus.fail_cnt};
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s t=%0t right/wrong/buzz/busy/fails observed=%b expected=%b", tag, $time, obs, expv);
    end
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0, tag);
  endtask

  task automatic enter(input int a, input int b, input int c, input int d, input string tag);
    step(1'b1, a, 1'b0, 1'b0, tag);
    step(1'b1, b, 1'b0, 1'b0, tag);
    step(1'b1, c, 1'b0, 1'b0, tag);
    step(1'b1, d, 1'b0, 1'b0, tag);
  endtask

  initial begin
    bus.key_vld = 1'b0; bus.key_code = '0; bus.prog_req = 1'b0; clear = 1'b1;
    step(1'b0, 0, 1'b0, 1'b1, "reset");
    step(1'b0, 0, 1'b0, 1'b1, "reset");
    idle(2, "reset_idle");

    enter(1, 2, 3, 4, "open_key"); idle(HOLD + 3, "open_hold");
    enter(1, 2, 3, 1, "wrong_key"); idle(HOLD + 3, "wrong_hold");
    enter(4, 3, 2, 1, "wrong2"); idle(HOLD + 2, "wrong2_hold");
    enter(0, 2, 3, 4, "wrong3_zero");
    for (int i = 0; i < LOCK + 2; i++) step(1'b1, (i % 4) + 1, 1'b0, 1'b0, "lockout_keys");
    idle(2, "after_lockout");
    enter(1, 2, 3, 4, "open_after_lock"); idle(HOLD + 2, "open_after_lock_hold");

    enter(2, 2, 2, 2, "fail_before_timeout"); idle(HOLD + 2, "fail_hold");
    step(1'b1, 1, 1'b0, 1'b0, "tmo_k1"); step(1'b1, 2, 1'b0, 1'b0, "tmo_k2");
    idle(TMO + 2, "timeout_idle");
    enter(1, 2, 3, 4, "open_after_tmo"); idle(HOLD + 2, "open_after_tmo_hold");
    step(1'b1, 1, 1'b0, 1'b0, "late_k1"); step(1'b1, 2, 1'b0, 1'b0, "late_k2");
    idle(TMO - 1, "late_wait");
    step(1'b1, 3, 1'b0, 1'b0, "late_k3"); step(1'b1, 4, 1'b0, 1'b0, "late_k4");
    idle(HOLD + 2, "late_hold");

    step(1'b1, 1, 1'b0, 1'b0, "clr_entry"); step(1'b1, 2, 1'b0, 1'b0, "clr_entry");
    step(1'b0, 0, 1'b0, 1'b1, "clear_mid_entry"); idle(3, "post_clear_entry");
    enter(5, 5, 5, 5, "lk1"); idle(HOLD + 1, "lk1h");
    enter(5, 5, 5, 5, "lk2"); idle(HOLD + 1, "lk2h");
    enter(5, 5, 5, 5, "lk3"); idle(6, "lk3_buzz");
    step(1'b0, 0, 1'b0, 1'b1, "clear_mid_lockout"); idle(3, "post_clear_lockout");

    enter(1, 2, 3, 4, "prog_open"); step(1'b0, 0, 1'b1, 1'b0, "prog_req");
    enter(4, 4, 4, 4, "prog_keys"); idle(HOLD + 2, "prog_done");
    enter(1, 2, 3, 4, "old_code"); idle(HOLD + 2, "old_code_hold");
    enter(4, 4, 4, 4, "new_code"); idle(HOLD + 2, "new_code_hold");
    step(1'b0, 0, 1'b0, 1'b1, "clear_code"); idle(2, "post_clear_code");

    for (int i = 0; i < 900; i++) begin
      bit v, p, c;
      int k;
      v = ($urandom_range(0, 9) < 4);
      k = ($urandom_range(0, 9) < 7) ? int'($urandom_range(1, 4)) : int'($urandom_range(0, 7));
      p = ($urandom_range(0, 15) == 0);
      c = ($urandom_range(0, 249) == 0);
      step(v, k, p, c, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
